// File: rtl/multu8_pkg.sv
// multu8_pkg: shared widths, saturation limit and operand/product types for multu8
package multu8_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  localparam logic [OP_W-1:0] OUT_MAX = 8'hFF;
  typedef logic [OP_W-1:0] operand_t;
  typedef logic [PROD_W-1:0] product_t;
endpackage

// File: rtl/multu8_if.sv
// multu8_if: operand/result handshake bundle between a producer and the multiplier
interface multu8_if;
  import multu8_pkg::*;
  logic in_valid;
  operand_t a;
  operand_t b;
  operand_t out;
  logic ovf;
  logic out_valid;
  modport master(output in_valid, a, b, input out, ovf, out_valid);
  modport slave(input in_valid, a, b, output out, ovf, out_valid);
endinterface

// File: rtl/multu8_pp_sum4.sv
// multu8_pp_sum4: sum of four shift-add partial products a<<(shift+i) gated by b[i]
module multu8_pp_sum4
  import multu8_pkg::*;
(
  input  operand_t     a_i,
  input  logic [3:0]   b_i,
  input  logic [2:0]   shift_i,
  output product_t     sum_o
);
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < 4; i++)
      sum_o = sum_o + (b_i[i] ? (product_t'(a_i) << (shift_i + 3'(i))) : '0);
  end
endmodule

// File: rtl/multu8.sv
// multu8: 2-stage pipelined unsigned 8x8 multiplier reduced to 8 bits by saturation or wrap
module multu8
  import multu8_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input logic       clk,
  input logic       rst,
  multu8_if.slave   bus
);
  product_t s_lo_d, s_hi_d, s_lo_q, s_hi_q, p;
  operand_t out_d, out_q;
  logic v1_q, ovf_d, ovf_q, vld_q;
  multu8_pp_sum4 u_lo (.a_i(bus.a), .b_i(bus.b[3:0]), .shift_i(3'd0), .sum_o(s_lo_d));
  multu8_pp_sum4 u_hi (.a_i(bus.a), .b_i(bus.b[7:4]), .shift_i(3'd4), .sum_o(s_hi_d));
  always_comb begin
    p = s_lo_q + s_hi_q;
    ovf_d = |p[PROD_W-1:OP_W];
    out_d = (SATURATE && ovf_d) ? OUT_MAX : p[OP_W-1:0];
  end
  // the data path runs every cycle; only the valid bit qualifies it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_lo_q <= '0;
      s_hi_q <= '0;
      v1_q   <= 1'b0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_lo_q <= s_lo_d;
      s_hi_q <= s_hi_d;
      v1_q   <= bus.in_valid;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
      vld_q  <= v1_q;
    end
  end
  assign bus.out = out_q;
  assign bus.ovf = ovf_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_multu8.sv
// tb_multu8: checks saturating and wrapping multu8 against an a*b reference model
module tb_multu8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v_s = 1'b0;
  logic [7:0] a_s = '0, b_s = '0;
  int ntests = 0, nfail = 0;
  typedef struct {bit v; int a; int b;} smp_t;
  typedef struct {int a; int b; int s; int w; bit o;} vec_t;
  smp_t hist[$];
  vec_t tbl[8];
  multu8_if ifs ();
  multu8_if ifw ();
  assign ifs.in_valid = v_s;
  assign ifs.a = a_s;
  assign ifs.b = b_s;
  assign ifw.in_valid = v_s;
  assign ifw.a = a_s;
  assign ifw.b = b_s;
  multu8 #(.SATURATE(1'b1)) dut_sat (.clk(clk), .rst(rst), .bus(ifs.slave));
  multu8 #(.SATURATE(1'b0)) dut_wrap (.clk(clk), .rst(rst), .bus(ifw.slave));
  always #5 clk = ~clk;

  function automatic int ref_out(int a, int b, bit sat);
    int p = a * b;
    return (p > 255) ? (sat ? 255 : p % 256) : p;
  endfunction

  task automatic chk(string nm, int act, int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    smp_t e;
    bit ev = 1'b0;
    if (hist.size() >= 2) begin
      e = hist[hist.size()-2];
      ev = e.v;
      chk("sat_out", int'(ifs.out), ref_out(e.a, e.b, 1'b1));
      chk("wrap_out", int'(ifw.out), ref_out(e.a, e.b, 1'b0));
      chk("ovf", int'(ifs.ovf), int'(e.a * e.b > 255));
      chk("wrap_ovf", int'(ifw.ovf), int'(e.a * e.b > 255));
    end
    chk("sat_valid", int'(ifs.out_valid), int'(ev));
    chk("wrap_valid", int'(ifw.out_valid), int'(ev));
  endtask

  task automatic cyc(bit v, int a, int b);
    smp_t s;
    v_s = v;
    a_s = 8'(a);
    b_s = 8'(b);
    @(posedge clk);
    if (!rst) begin
      s.v = v; s.a = a; s.b = b;
      hist.push_back(s);
      if (hist.size() > 2) void'(hist.pop_front());
    end
    #1;
    check_model();
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_out"}, int'(ifs.out) + int'(ifw.out), 0);
    chk({nm, "_ovf"}, int'(ifs.ovf) + int'(ifw.ovf), 0);
    chk({nm, "_valid"}, int'(ifs.out_valid) + int'(ifw.out_valid), 0);
  endtask

  initial begin
    tbl[0] = '{15, 17, 255, 255, 1'b0};
    tbl[1] = '{16, 16, 255, 0, 1'b1};
    tbl[2] = '{255, 255, 255, 1, 1'b1};
    tbl[3] = '{1, 255, 255, 255, 1'b0};
    tbl[4] = '{20, 13, 255, 4, 1'b1};
    tbl[5] = '{0, 200, 0, 0, 1'b0};
    tbl[6] = '{9, 9, 81, 81, 1'b0};
    tbl[7] = '{7, 6, 42, 42, 1'b0};
    #1 chk_zero("por");
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++) cyc(1'b1, a, b);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, tbl[i].a, tbl[i].b);
      cyc(1'b0, 0, 0);
      chk("tbl_sat", int'(ifs.out), tbl[i].s);
      chk("tbl_wrap", int'(ifw.out), tbl[i].w);
      chk("tbl_ovf", int'(ifs.ovf), int'(tbl[i].o));
      chk("tbl_valid", int'(ifs.out_valid), 1);
    end
    foreach (tbl[i]) cyc(1'b1, tbl[i].a, tbl[i].b);
    cyc(1'b1, 3, 5); cyc(1'b0, 3, 5); cyc(1'b1, 3, 5); cyc(1'b1, 3, 5); cyc(1'b0, 3, 5);
    cyc(1'b0, 3, 5); cyc(1'b0, 3, 5);
    // async reset with no clock edge in between
    cyc(1'b1, 200, 200);
    #3 rst = 1'b1;
    hist.delete();
    #1 chk_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 255, 255);
      chk_zero("rst_hold");
    end
    rst = 1'b0;
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    // reset while 200x2 and 9x9 are in flight
    cyc(1'b1, 200, 2);
    v_s = 1'b1; a_s = 8'd9; b_s = 8'd9;
    #2 rst = 1'b1;
    hist.delete();
    #1 chk_zero("mid_rst");
    for (int i = 0; i < 3; i++) cyc(1'b1, 9, 9);
    rst = 1'b0;
    cyc(1'b0, 0, 0);
    cyc(1'b1, 4, 4);
    chk("post_rst_early", int'(ifs.out_valid), 0);
    cyc(1'b0, 0, 0);
    chk("post_rst_out", int'(ifs.out), 16);
    chk("post_rst_valid", int'(ifs.out_valid), 1);
    cyc(1'b0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/multu8.md
Name: multu8

Overview:
- Pipelined unsigned 8x8-bit multiplier with an 8-bit result.
- Used as the per-processing-element multiply in the systolic convolution array; one operand pair is accepted per clock.
- Full 16-bit product is formed from an explicit shift-add partial-product array, then reduced to 8 bits by saturation (default) or wrap.
- Provides a valid handshake and an overflow flag.

Parameters:
- SATURATE, 1: 1 = clamp result to 255 when the product exceeds 255; 0 = output the low 8 bits of the product (mod 256).

Ports:
- clk  input  1  single clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a/b qualify this cycle.
- a  input  8  unsigned multiplicand.
- b  input  8  unsigned multiplier.
- out  output  8  reduced product, registered.
- ovf  output  1  full product > 255, registered and aligned with out.
- out_valid  output  1  out/ovf qualify this cycle.

Behaviour:
- Interface:
  - One clock (clk); reset rst is asynchronous and active-high.
  - While rst=1, every pipeline register clears immediately, independent of clk: out=0, ovf=0, out_valid=0.
- Arithmetic:
  - Unsigned only.
  - pp[i] = b[i] ? (a << i) : 0, for i = 0..7, each 16 bits wide.
  - P = sum of pp[0..7], 16 bits; no carry is lost.
- Pipeline (2-cycle latency, throughput 1 per cycle, no stall/backpressure):
  - Stage 1, at edge N: register s_lo = pp0+pp1+pp2+pp3 and s_hi = pp4+pp5+pp6+pp7 (both 16 bits), plus v1 = in_valid.
  - Stage 2, at edge N+1: compute P = s_lo + s_hi and register:
    - ovf = (P[15:8] != 0)
    - out = SATURATE ? (ovf ? 8'hFF : P[7:0]) : P[7:0]
    - out_valid = v1
  - Operands sampled at edge N therefore appear on out after edge N+1, i.e. two rising edges after being presented.
- Data path is not gated by in_valid: a/b are always multiplied. out_valid is the only qualifier. Downstream logic must ignore out/ovf when out_valid=0.
- Boundaries:
  - 0 × anything = 0, ovf=0.
  - 255 × 255 = 65025 (0xFE01) → out=255 (SATURATE=1) or 0x01 (SATURATE=0), ovf=1.
  - 15 × 17 = 255 → out=255, ovf=0 (exact fit, not overflow).
  - 16 × 16 = 256 → out=255/0x00, ovf=1.
- Reset mid-operation: in-flight operands are discarded. After rst deasserts, the first out_valid=1 occurs two edges after the first sampled in_valid=1.
- Back-to-back operands are independent; there is no state carried between results.
- No X propagation from reset: all registers have reset values.

Decomposition:
- Shared package multu8_pkg:
  - OP_W=8, PROD_W=16, OUT_MAX=8'hFF
  - typedef operand_t (8-bit unsigned)
  - typedef product_t (16-bit unsigned)
- One sub-module, multu8_pp_sum4: combinational.
  - Inputs: operand a, 4 bits of b, base shift (0 or 4).
  - Output: 16-bit sum of those four partial products.
  - Instantiated twice in stage 1.
- Saturation/reduction stays in the top module.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge → out=0, ovf=0, out_valid=0 immediately; hold 3 cycles, outputs stay 0.
- Small sweep: in_valid=1, a=0..9 × b=0..9, one pair per cycle → each out = a*b (e.g. 9×9=81, 7×6=42), ovf=0, exactly two edges after presentation, out_valid continuous.
- Overflow edges (SATURATE=1):
  - 15×17 → 255, ovf=0.
  - 16×16 → 255, ovf=1.
  - 255×255 → 255, ovf=1.
  - 1×255 → 255, ovf=0.
- Wrap mode (SATURATE=0):
  - 255×255 → 0x01, ovf=1.
  - 16×16 → 0x00, ovf=1.
  - 20×13=260 → 0x04, ovf=1.
- Valid gating: pattern in_valid = 1,0,1,1,0 with a=3,b=5 held → out_valid = same pattern delayed two edges; out=15 in every cycle, qualified only when out_valid=1.
- Reset mid-pipeline: present 200×2 then 9×9 and assert rst one edge later → no out_valid pulse for either pair. After release, 4×4 → out=16, out_valid after two edges.
